rom_uart_sequencer: RTL
=======================

// Module: rom_uart_sequencer
// PURPOSE
//  Frame sequencer between a synchronous byte ROM and the uart transmitter. On a start
//  pulse, or automatically every PERIOD cycles, it reads ROM[0..LAST_ADDR] in order and
//  hands each byte to the uart with the tx_en/tx_busy handshake. One byte is in flight at a time.
// PARAMETERS
//  ADDR_W     4         ROM address width
//  LAST_ADDR  1         last ROM address sent per frame (frame = LAST_ADDR+1 bytes)
//  PERIOD     30000000  auto-repeat interval in sys_clk cycles; 0 = manual start only
// PORTS
//  sys_clk        in   1       system clock; all logic on posedge
//  sys_rst_n      in   1       asynchronous active-low reset
//  start          in   1       1-cycle frame request
//  rom_addr       out  ADDR_W  ROM read address
//  rom_data       in   8       ROM read data, valid 1 cycle after rom_addr
//  uart_tx_en     out  1       send request to uart
//  uart_tx_data   out  8       byte to send; stable while uart_tx_en=1
//  uart_tx_busy   in   1       uart shifting a byte
//  frame_busy     out  1       1 from frame accept until frame_done
//  frame_done     out  1       1-cycle pulse after the last byte's tx_busy falls
//  led            out  1       toggles on every frame_done
// BEHAVIOUR
//  Reset: state IDLE; rom_addr=0, uart_tx_en=0, uart_tx_data=0, frame_busy=0, frame_done=0,
//   led=0, period counter=0. Assertion mid-frame aborts the frame immediately; no partial resume.
//  States: IDLE -> FETCH -> LATCH -> SEND -> DRAIN -> (FETCH | [CSUM] | DONE) -> IDLE.
//  IDLE: start=1, or period counter == PERIOD-1 with PERIOD!=0, -> FETCH.
//   rom_addr=0; frame_busy=1 from the next cycle.
//  FETCH: one cycle for the ROM read latency. LATCH: capture rom_data into uart_tx_data.
//  SEND: stay in SEND while uart_tx_busy=1, so a pre-existing transfer is never overrun.
//   Once busy=0, assert uart_tx_en. Hold it and the data until busy=1 is sampled.
//   Then drop uart_tx_en in that cycle and go to DRAIN.
//  DRAIN: wait for uart_tx_busy=0.
//   If rom_addr == LAST_ADDR, go to DONE (or CSUM); otherwise rom_addr+1 and go to FETCH.
//  DONE: frame_done=1 for 1 cycle, led toggles, frame_busy=0, rom_addr wraps to 0, go to IDLE.
//  Minimum cost per byte is 4 cycles of overhead plus the uart byte time.
//  Period counter: $clog2(PERIOD+1) bits. Counts only in IDLE; cleared on frame accept.
//   With start and expiry in the same cycle, exactly one frame is started.
//  start while frame_busy=1 is ignored (no queueing).
//  LAST_ADDR >= 2**ADDR_W is illegal; it is caught by an elaboration-time check.
// CONFIGURATION
//  ROM_SEQ_CHECKSUM_EN defined: running XOR of all frame bytes, cleared at frame accept.
//   After the last byte's DRAIN, CSUM sends the XOR byte with the same SEND/DRAIN handshake,
//   then goes to DONE. Frame length = LAST_ADDR+2 bytes.
//  Undefined: no CSUM state and no XOR register; frame length = LAST_ADDR+1.
// STRUCTURE
//  Package rom_seq_pkg: state encoding constants (IDLE, FETCH, LATCH, SEND, DRAIN, CSUM, DONE)
//   and BYTE_W=8.
//  One sub-module, rom_seq_period_timer: period counter producing a 1-cycle expiry
//   with enable and clear inputs.
//  The FSM and the handshake stay in the top level.
// TESTING
//  Bench drives a 2-entry ROM model (A5, 3C) with 1-cycle latency and a uart model
//   (busy rises 1 cycle after tx_en, lasts 10 cycles).
//  T1 start pulse, PERIOD=0 -> bytes A5 then 3C; exactly 2 tx_en episodes.
//   frame_done 1 cycle after the second busy falls; led=1.
//  T2 uart_tx_busy held 1 for 20 cycles before start -> uart_tx_en stays 0 until busy=0.
//   First byte is still A5.
//  T3 PERIOD=50, no start -> frames repeat back to back.
//   Each accept comes 50 IDLE cycles after the previous frame_done; led toggles each frame.
//  T4 sys_rst_n low during the second byte's SEND -> all outputs 0 asynchronously.
//   After release: IDLE, and the next start resends from A5.
//  T5 start during frame_busy, and start coinciding with period expiry -> exactly one frame each.
//  T6 ROM_SEQ_CHECKSUM_EN defined -> sequence A5, 3C, 99; frame_done after the third byte.

Source files
------------

// File: rtl/rom_seq_pkg.sv
// ----------------------------------------------------------------------------
// rom_seq_pkg
//   Shared constants for the ROM-to-UART frame sequencer.
//   BYTE_W    : width of a ROM word / UART byte
//   ST_*      : FSM state encoding used by rom_uart_sequencer
// ----------------------------------------------------------------------------
package rom_seq_pkg;

    localparam int BYTE_W = 8;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_LATCH = 3'd2;
    localparam logic [2:0] ST_SEND  = 3'd3;
    localparam logic [2:0] ST_DRAIN = 3'd4;
    localparam logic [2:0] ST_CSUM  = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;

endpackage

// File: rtl/rom_seq_period_timer.sv
// ----------------------------------------------------------------------------
// rom_seq_period_timer
//   Free-running interval counter that raises a 1-cycle expiry after PERIOD
//   enabled cycles. PERIOD=0 disables the timer entirely (expire tied low).
// Ports:
//   clk     in  clock, posedge
//   rst_n   in  asynchronous active-low reset
//   en      in  count this cycle
//   clr     in  return counter to 0 (wins over en)
//   expire  out 1 when en=1 and the counter holds PERIOD-1
// ----------------------------------------------------------------------------
module rom_seq_period_timer #(
    parameter int PERIOD = 30000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic expire
);

    generate
        if (PERIOD == 0) begin : g_off
            // Manual-start-only build: nothing to count.
            logic unused_inputs;
            assign unused_inputs = ^{clk, rst_n, en, clr};
            assign expire        = 1'b0;
        end else begin : g_on
            localparam int CNT_W = $clog2(PERIOD + 1);

            logic [CNT_W-1:0] cnt_q;
            logic [CNT_W-1:0] cnt_d;
            logic             hit;

            assign hit    = (cnt_q == CNT_W'(PERIOD - 1));
            assign expire = en && hit;

            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (en) begin
                    cnt_d = hit ? '0 : cnt_q + CNT_W'(1);
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/rom_uart_sequencer.sv
// ----------------------------------------------------------------------------
// rom_uart_sequencer
//   Reads ROM[0..LAST_ADDR] in order on a start pulse (or every PERIOD cycles
//   when PERIOD!=0) and hands each byte to a UART transmitter using the
//   tx_en / tx_busy handshake, one byte in flight at a time.
//   Build option: define ROM_SEQ_CHECKSUM_EN to append the XOR of all frame
//   bytes as an extra trailing byte.
// Ports:
//   sys_clk       in   system clock, posedge
//   sys_rst_n     in   asynchronous active-low reset
//   start         in   1-cycle frame request (ignored while a frame runs)
//   rom_addr      out  ROM read address
//   rom_data      in   ROM read data, valid 1 cycle after rom_addr
//   uart_tx_en    out  send request, held with data until busy is seen
//   uart_tx_data  out  byte to send
//   uart_tx_busy  in   UART is shifting a byte
//   frame_busy    out  high from the cycle after accept until frame_done
//   frame_done    out  1-cycle pulse after the last byte drains
//   led           out  toggles on every frame_done
// ----------------------------------------------------------------------------
module rom_uart_sequencer
    import rom_seq_pkg::*;
#(
    parameter int ADDR_W    = 4,
    parameter int LAST_ADDR = 1,
    parameter int PERIOD    = 30000000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [BYTE_W-1:0] rom_data,
    output logic              uart_tx_en,
    output logic [BYTE_W-1:0] uart_tx_data,
    input  logic              uart_tx_busy,
    output logic              frame_busy,
    output logic              frame_done,
    output logic              led
);

    generate
        if (LAST_ADDR < 0 || LAST_ADDR >= (1 << ADDR_W)) begin : g_bad_last_addr
            $error("rom_uart_sequencer: LAST_ADDR does not fit in ADDR_W bits");
        end
    endgenerate

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              tx_en_q, tx_en_d;
    logic              led_q, led_d;
    logic              accept;
    logic              expire;
    logic              last_byte;
`ifdef ROM_SEQ_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              csum_sent_q, csum_sent_d;
`endif

    // Start and timer expiry in the same cycle collapse into one accept.
    assign accept    = (state_q == ST_IDLE) && (start || expire);
    assign last_byte = (addr_q == ADDR_W'(LAST_ADDR));

    rom_seq_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .en     (state_q == ST_IDLE),
        .clr    (accept),
        .expire (expire)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        tx_en_d = tx_en_q;
        led_d   = led_q;
`ifdef ROM_SEQ_CHECKSUM_EN
        csum_d      = csum_q;
        csum_sent_d = csum_sent_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = '0;
                    state_d = ST_FETCH;
`ifdef ROM_SEQ_CHECKSUM_EN
                    csum_d      = '0;
                    csum_sent_d = 1'b0;
`endif
                end
            end
            ST_FETCH: state_d = ST_LATCH;
            ST_LATCH: begin
                data_d  = rom_data;
                state_d = ST_SEND;
`ifdef ROM_SEQ_CHECKSUM_EN
                csum_d = csum_q ^ rom_data;
`endif
            end
            ST_SEND: begin
                // Request only once the UART is idle; then hold the request
                // until the UART acknowledges by raising busy.
                if (!tx_en_q) begin
                    if (!uart_tx_busy) begin
                        tx_en_d = 1'b1;
                    end
                end else if (uart_tx_busy) begin
                    tx_en_d = 1'b0;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!uart_tx_busy) begin
`ifdef ROM_SEQ_CHECKSUM_EN
                    if (csum_sent_q) begin
                        state_d = ST_DONE;
                    end else if (last_byte) begin
                        state_d = ST_CSUM;
                    end else begin
`else
                    if (last_byte) begin
                        state_d = ST_DONE;
                    end else begin
`endif
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = ST_FETCH;
                    end
                end
            end
`ifdef ROM_SEQ_CHECKSUM_EN
            ST_CSUM: begin
                data_d      = csum_q;
                csum_sent_d = 1'b1;
                state_d     = ST_SEND;
            end
`endif
            ST_DONE: begin
                led_d   = ~led_q;
                addr_d  = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            tx_en_q <= 1'b0;
            led_q   <= 1'b0;
`ifdef ROM_SEQ_CHECKSUM_EN
            csum_q      <= '0;
            csum_sent_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            tx_en_q <= tx_en_d;
            led_q   <= led_d;
`ifdef ROM_SEQ_CHECKSUM_EN
            csum_q      <= csum_d;
            csum_sent_q <= csum_sent_d;
`endif
        end
    end

    assign rom_addr     = addr_q;
    assign uart_tx_en   = tx_en_q;
    assign uart_tx_data = data_q;
    assign frame_busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign frame_done   = (state_q == ST_DONE);
    assign led          = led_q;

endmodule
